// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: requester drives start and
// operands, the adder returns status and the registered result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder stage plus registered carry,
// consuming operands LSB-first, one bit per clock.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             s_bit;
  logic             c_bit;
  logic [WIDTH-1:0] ra_shift;

  assign s_bit = ra_q[0] ^ rb_q[0] ^ carry_q;
  assign c_bit = (ra_q[0] & rb_q[0]) | (ra_q[0] & carry_q) | (rb_q[0] & carry_q);

  // Sum bits enter ra at the MSB as operand bits leave at the LSB, so after
  // WIDTH shifts ra holds the complete partial sum.
  generate
    if (WIDTH == 1) begin : g_one
      assign ra_shift = s_bit;
    end else begin : g_multi
      assign ra_shift = {s_bit, ra_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          ra_d    = bus.a;
          rb_d    = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ra_d    = ra_shift;
        rb_d    = rb_q >> 1;
        carry_d = c_bit;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          sum_d   = ra_shift;
          cout_d  = c_bit;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1 driven side by side;
// a cycle model predicts busy/done and the expected {cout,sum}.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(1)) if1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  logic       st[2];
  logic       by[2];
  logic       dn[2];
  logic [8:0] res[2];
  logic [8:0] exp_in[2];

  assign st[0]     = if8.start;
  assign by[0]     = if8.busy;
  assign dn[0]     = if8.done;
  assign res[0]    = {if8.cout, if8.sum};
  assign exp_in[0] = {1'b0, if8.a} + {1'b0, if8.b} + {8'b0, if8.cin};
  assign st[1]     = if1.start;
  assign by[1]     = if1.busy;
  assign dn[1]     = if1.done;
  assign res[1]    = {7'b0, if1.cout, if1.sum};
  assign exp_in[1] = {7'b0, 2'({1'b0, if1.a} + {1'b0, if1.b} + {1'b0, if1.cin})};

  int         mcnt[2] = '{0, 0};
  logic [8:0] last[2] = '{9'd0, 9'd0};
  logic [8:0] expq[2][$];

  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  logic end_req = 1'b0;
  logic end_ack = 1'b0;

  // Reference cycle model: an accepted start keeps the adder busy WIDTH+1
  // cycles, the last of which is the done cycle carrying the popped result.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mcnt[k] <= 0;
        last[k] <= 9'd0;
        expq[k].delete();
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (mcnt[k] == 0) begin
          if (st[k]) begin
            expq[k].push_back(exp_in[k]);
            mcnt[k] <= (k == 0) ? 9 : 2;
          end
        end else begin
          if (mcnt[k] == 2) last[k] <= expq[k].pop_front();
          mcnt[k] <= mcnt[k] - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input int k, input logic [8:0] obs, input logic [8:0] exp_v);
    checks++;
    assert (obs === exp_v) passes++;
    else begin
      fails++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp_v);
    end
  endtask

  // Sampled just after each falling clock edge and just after reset assertion.
  always begin
    @(negedge clk or negedge rst_n);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("busy", k, 9'(by[k]), 9'(mcnt[k] != 0));
      chk("done", k, 9'(dn[k]), 9'(mcnt[k] == 1));
      chk("result", k, res[k], last[k]);
    end
    if (end_req && !end_ack) begin
      for (int k = 0; k < 2; k++) chk("queue_empty", k, 9'(expq[k].size()), 9'd0);
      end_ack = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [7:0] a, input logic [7:0] b, input logic c);
    if8.start = s; if8.a = a; if8.b = b; if8.cin = c;
    if1.start = s; if1.a = a[0]; if1.b = b[0]; if1.cin = c;
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic c);
    drive(1'b1, a, b, c);
    tick(1);
    drive(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    tick(9);
  endtask

  initial begin
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    op(8'h3C, 8'h5A, 1'b0);
    op(8'hFF, 8'h01, 1'b0);
    op(8'hFF, 8'hFF, 1'b1);

    // Start pulses during SHIFT and DONE must be ignored by the 8-bit adder.
    drive(1'b1, 8'h10, 8'h20, 1'b0);
    tick(1);
    drive(1'b0, 8'h10, 8'h20, 1'b0);
    tick(3);
    drive(1'b1, 8'hAA, 8'h55, 1'b0);
    tick(1);
    drive(1'b0, 8'hAA, 8'h55, 1'b0);
    tick(4);
    drive(1'b1, 8'hAA, 8'h55, 1'b0);
    tick(1);
    drive(1'b0, 8'hAA, 8'h55, 1'b0);
    tick(4);

    // Reset asserted mid-operation, then a clean operation afterwards.
    drive(1'b1, 8'h7F, 8'h01, 1'b0);
    tick(1);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    tick(3);
    #2 rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    op(8'h01, 8'h02, 1'b0);

    // Back-to-back with start held high.
    drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    for (int i = 0; i < 6; i++) begin
      tick(1);
      drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      tick(9);
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    tick(10);

    for (int i = 0; i < 1000; i++) op(8'($urandom), 8'($urandom), 1'($urandom));
    tick(3);

    end_req = 1'b1;
    for (int i = 0; i < 5 && !end_ack; i++) tick(1);
    if (!end_ack) begin
      $display("FAIL end_handshake observed=0 expected=1");
      $fatal(1, "monitor did not acknowledge end of run");
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
